// File: rtl/chan_scan_pkg.sv
// chan_scan_pkg
//   Shared definitions for the channel scan multiplexer.
//   - mode_e : encoding of the 2-bit mode input (reserved code acts as HOLD)
//   - clog2  : ceiling log2, used to size the channel select
package chan_scan_pkg;

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'd0,
        MODE_SCAN   = 2'd1,
        MODE_HOLD   = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    // Smallest r with 2**r >= v; callers only pass v >= 2.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/onehot_dec.sv
// onehot_dec
//   Combinational SW-to-N one-hot decoder. An index with no matching
//   channel (idx >= N) produces an all-zero vector.
// Ports:
//   idx  in  SW  channel index
//   oh   out N   one-hot decode of idx
module onehot_dec #(
    parameter int N  = 32,
    parameter int SW = 5
) (
    input  logic [SW-1:0] idx,
    output logic [N-1:0]  oh
);

    always_comb begin
        oh = '0;
        for (int i = 0; i < N; i++) begin
            oh[i] = (idx == SW'(i));
        end
    end

endmodule

// File: rtl/chan_scan_mux.sv
// chan_scan_mux
//   Registered N-to-1 channel selector with DIRECT, SCAN and HOLD modes.
//   In SCAN the index walks 0..N-1 and wraps, and each full sweep is
//   assembled into an N-bit snapshot word.
// Ports:
//   clk       in  1   rising-edge clock
//   rst_n     in  1   synchronous active-low reset
//   in_bits   in  N   channel inputs
//   mode      in  2   0 DIRECT, 1 SCAN, 2 HOLD, 3 reserved (HOLD)
//   sel       in  SW  requested channel (DIRECT only)
//   y         out 1   selected bit, registered
//   out_sel   out SW  index that produced the current y
//   sel_err   out 1   pulse: out-of-range DIRECT sel rejected
//   cap_word  out N   last complete scan snapshot (bit k = channel k)
//   cap_valid out 1   pulse: cap_word just updated
module chan_scan_mux
    import chan_scan_pkg::*;
#(
    parameter  int N  = 32,
    localparam int SW = clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  in_bits,
    input  logic [1:0]    mode,
    input  logic [SW-1:0] sel,
    output logic          y,
    output logic [SW-1:0] out_sel,
    output logic          sel_err,
    output logic [N-1:0]  cap_word,
    output logic          cap_valid
);

    // One extra bit so N itself is representable when N is a power of two.
    localparam logic [SW:0]   N_EXT = (SW+1)'(N);
    localparam logic [SW-1:0] LAST  = SW'(N - 1);

    logic [SW-1:0] sel_q;
    mode_e         mode_q;
    logic          y_scan;
    logic [N-1:0]  part;
    logic          sweep_ok;

    logic [N-1:0]  sel_oh;
    logic          y_next;
    logic          scan_now;
    logic          scan_entry;
    logic          sel_ok;

    onehot_dec #(
        .N  (N),
        .SW (SW)
    ) u_dec (
        .idx (sel_q),
        .oh  (sel_oh)
    );

    // Decode-AND-OR selection: no priority chain.
    assign y_next     = |(sel_oh & in_bits);
    assign scan_now   = (mode == MODE_SCAN);
    assign scan_entry = scan_now && (mode_q != MODE_SCAN);
    assign sel_ok     = ({1'b0, sel} < N_EXT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_q     <= '0;
            mode_q    <= MODE_HOLD;
            y_scan    <= 1'b0;
            part      <= '0;
            sweep_ok  <= 1'b0;
            y         <= 1'b0;
            out_sel   <= '0;
            sel_err   <= 1'b0;
            cap_word  <= '0;
            cap_valid <= 1'b0;
        end else begin
            sel_err   <= 1'b0;
            cap_valid <= 1'b0;
            mode_q    <= mode_e'(mode);

            // Output stage: y/out_sel always trail sel_q by one edge.
            y       <= y_next;
            out_sel <= sel_q;
            y_scan  <= scan_now && !scan_entry;

            // Index update.
            case (mode)
                MODE_DIRECT: begin
                    if (sel_ok) sel_q <= sel;
                    else        sel_err <= 1'b1;
                end
                MODE_SCAN: begin
                    if (scan_entry)          sel_q <= '0;
                    else if (sel_q == LAST)  sel_q <= '0;
                    else                     sel_q <= sel_q + SW'(1);
                end
                default: ;  // HOLD / reserved: index frozen
            endcase

            // Snapshot assembly. Leaving SCAN kills the sweep, including
            // a scan sample still sitting in y.
            if (!scan_now) begin
                sweep_ok <= 1'b0;
                part     <= '0;
            end else if (scan_entry) begin
                sweep_ok <= 1'b1;
                part     <= '0;
            end else if (y_scan && sweep_ok) begin
                if (out_sel == LAST) begin
                    cap_word  <= {y, part[N-2:0]};
                    cap_valid <= 1'b1;
                    part      <= '0;
                end else begin
                    part[out_sel] <= y;
                end
            end
        end
    end

endmodule

// File: tb/tb_chan_scan_mux.sv
// tb_chan_scan_mux
//   Directed bench for chan_scan_mux with three instances (N = 32, 20, 5)
//   sharing clock and reset.
module tb_chan_scan_mux;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // N = 32
    logic [31:0] in32 = '0;
    logic [1:0]  mode32 = 2'd0;
    logic [4:0]  sel32 = '0;
    logic        y32, se32, cv32;
    logic [4:0]  os32;
    logic [31:0] cw32;
    // N = 20
    logic [19:0] in20 = '0;
    logic [1:0]  mode20 = 2'd0;
    logic [4:0]  sel20 = '0;
    logic        y20, se20, cv20;
    logic [4:0]  os20;
    logic [19:0] cw20;
    // N = 5
    logic [4:0]  in5 = '0;
    logic [1:0]  mode5 = 2'd0;
    logic [2:0]  sel5 = '0;
    logic        y5, se5, cv5;
    logic [2:0]  os5;
    logic [4:0]  cw5;

    chan_scan_mux #(.N(32)) u32 (
        .clk(clk), .rst_n(rst_n), .in_bits(in32), .mode(mode32), .sel(sel32),
        .y(y32), .out_sel(os32), .sel_err(se32), .cap_word(cw32), .cap_valid(cv32));
    chan_scan_mux #(.N(20)) u20 (
        .clk(clk), .rst_n(rst_n), .in_bits(in20), .mode(mode20), .sel(sel20),
        .y(y20), .out_sel(os20), .sel_err(se20), .cap_word(cw20), .cap_valid(cv20));
    chan_scan_mux #(.N(5)) u5 (
        .clk(clk), .rst_n(rst_n), .in_bits(in5), .mode(mode5), .sel(sel5),
        .y(y5), .out_sel(os5), .sel_err(se5), .cap_word(cw5), .cap_valid(cv5));

    int errors = 0;
    int checks = 0;
    int hits;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle; outputs read here belong to that edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---- reset with all-ones inputs
        in32 = '1; in20 = '1; in5 = '1;
        step(); step();
        chk("rst_y", y32, 0);
        chk("rst_out_sel", os32, 0);
        chk("rst_cap_word", cw32, 0);
        chk("rst_cap_valid", cv32, 0);
        chk("rst_sel_err", se32, 0);
        rst_n = 1'b1;
        step(); step();
        chk("post_rst_y", y32, 1);

        // ---- DIRECT, N = 32
        in32 = 32'h8000_0001;
        sel32 = 5'd0;  step();
        sel32 = 5'd31; step();
        chk("dir_y0", y32, 1);  chk("dir_os0", os32, 0);
        sel32 = 5'd5;  step();
        chk("dir_y31", y32, 1); chk("dir_os31", os32, 31);
        step();
        chk("dir_y5", y32, 0);  chk("dir_os5", os32, 5);

        // ---- out of range, N = 20
        in20 = 20'h8_0000;
        sel20 = 5'd19; step();
        sel20 = 5'd25; step();
        chk("oor_err", se20, 1); chk("oor_os", os20, 19); chk("oor_y", y20, 1);
        sel20 = 5'd19; in20 = 20'h0_0000; step();
        chk("oor_err_clr", se20, 0); chk("oor_os_hold", os20, 19); chk("oor_y_follow", y20, 0);

        // ---- full sweep, N = 32
        in32 = 32'hDEAD_BEEF; mode32 = 2'd1;
        step();                       // entry edge E
        hits = 0;
        for (int j = 1; j <= 32; j++) begin step(); if (cv32) hits++; end
        chk("sweep_early_cv", hits, 0);
        step();                       // cycle E+34
        chk("sweep1_cv", cv32, 1); chk("sweep1_word", cw32, 32'hDEAD_BEEF);
        hits = 0;
        for (int j = 34; j <= 64; j++) begin step(); if (cv32) hits++; end
        chk("sweep_gap_cv", hits, 0);
        step();
        chk("sweep2_cv", cv32, 1); chk("sweep2_word", cw32, 32'hDEAD_BEEF);

        // ---- non-power-of-two wrap, N = 5 (out-of-range sel must not flag in SCAN)
        in5 = 5'b10110; sel5 = 3'd7; mode5 = 2'd1;
        step();                       // entry edge
        for (int j = 1; j <= 12; j++) begin
            step();
            chk($sformatf("wrap_os_%0d", j), os5, (j - 1) % 5);
            chk($sformatf("wrap_cv_%0d", j), cv5, (j == 6 || j == 11) ? 1 : 0);
            chk($sformatf("wrap_err_%0d", j), se5, 0);
            if (j == 6) chk("wrap_word", cw5, 5'b10110);
        end

        // ---- abort, N = 32
        mode32 = 2'd2; in32 = 32'h1234_5678;
        step();
        mode32 = 2'd1;
        step();                       // entry
        hits = 0;
        for (int j = 0; j < 10; j++) begin step(); if (cv32) hits++; end
        mode32 = 2'd2;
        for (int j = 0; j < 40; j++) begin step(); if (cv32) hits++; end
        chk("abort_cv", hits, 0);
        chk("abort_word_kept", cw32, 32'hDEAD_BEEF);
        mode32 = 2'd1;
        step();                       // re-entry E2
        step();
        chk("restart_os", os32, 0); chk("restart_cv", cv32, 0);
        hits = 0;
        for (int j = 2; j <= 32; j++) begin step(); if (cv32) hits++; end
        chk("restart_early_cv", hits, 0);
        step();
        chk("restart_cv_hit", cv32, 1); chk("restart_word", cw32, 32'h1234_5678);

        // ---- reset mid-sweep (u5 still scanning)
        rst_n = 1'b0;
        step();
        chk("midrst_os", os5, 0); chk("midrst_cv", cv5, 0); chk("midrst_word", cw5, 0);
        rst_n = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/chan_scan_mux.md
# chan_scan_mux

Parametrised, registered N-to-1 channel selector; the clocked successor of the team's combinational 32-to-1 decode-and-OR multiplexer. It adds three selection modes: direct, auto-scan and hold. It flags out-of-range selects, and in scan mode it assembles a full N-bit snapshot word, one channel per cycle. It sits between a bank of single-bit status/input lines and downstream logic that consumes either one selected bit per cycle or a periodic snapshot word.

## Interface
Parameters:
- N, 32, number of input channels; legal range 2..256; need not be a power of two.
- SW (localparam), clog2(N), select width.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  reset; synchronous, active-low.
- in_bits  in  N  channel inputs, sampled every cycle.
- mode  in  2  0 = DIRECT, 1 = SCAN, 2 = HOLD, 3 = reserved (behaves as HOLD).
- sel  in  SW  requested channel; used in DIRECT only.
- y  out  1  selected bit, registered.
- out_sel  out  SW  index that produced the current y.
- sel_err  out  1  one-cycle pulse: DIRECT sel >= N was rejected.
- cap_word  out  N  last complete scan snapshot; bit k = channel k.
- cap_valid  out  1  one-cycle pulse: cap_word has just been updated.

## Operation
- Internal registers:
  - sel_q (SW): current index.
  - mode_q: mode sampled on the previous edge.
  - y_scan: y came from a SCAN cycle.
  - part (N): partial snapshot.
  - sweep_ok: the sweep is intact.
- DIRECT: on each edge, if sel < N then sel_q <= sel. Otherwise sel_q holds and sel_err <= 1 for one cycle.
- SCAN entry (mode == SCAN and mode_q != SCAN): sel_q <= 0, part <= 0, sweep_ok <= 1.
- SCAN steady state: sel_q <= (sel_q == N-1) ? 0 : sel_q + 1. The wrap is explicit, so a non-power-of-two N never visits indices >= N.
- HOLD or reserved: sel_q holds; sel is ignored.
- Output stage, every edge: y <= in_bits[sel_q], out_sel <= sel_q, y_scan <= (mode == SCAN and not an entry cycle).
- Capture, at an edge where y_scan == 1 and sweep_ok == 1: part[out_sel] <= y.
  - If out_sel == N-1, cap_word <= part with bit N-1 replaced by y, then cap_valid <= 1 and part <= 0.
  - A sweep continues immediately: index 0 follows N-1.
- Leaving SCAN (mode != SCAN at an edge): sweep_ok <= 0 and part <= 0. Any in-flight scan sample in y is discarded, no cap_valid is produced, and cap_word retains its last value.
- The decode of sel_q to a one-hot vector, ANDed with in_bits and OR-reduced, is the selection path. No priority logic is used.

## Timing
- Reset (rst_n == 0 at an edge): sel_q, y, out_sel, cap_word, part are 0; sel_err, cap_valid, y_scan, sweep_ok are 0; mode_q = HOLD.
- Reset dominates every other input on the same edge. Reset asserted mid-sweep aborts the sweep.
- Latency from sel to sel_q is 1 edge (DIRECT). From sel_q to y/out_sel is 1 edge. So y reflects sel 2 edges after it is presented.
- First snapshot after SCAN entry:
  - The entry edge is E.
  - sel_q = k during cycle E+1+k.
  - The y for k = N-1 appears at E+N+1.
  - cap_valid is high during cycle E+N+2.
  - Later snapshots follow every N cycles.
- sel_err is asserted during the cycle after the offending edge. It cannot occur outside DIRECT.
- Mode changes take effect on the edge that samples them; there is no handshake. Back-to-back mode changes are legal.

## Structure
- Shared package chan_scan_pkg holds the mode encodings (MODE_DIRECT = 2'd0, MODE_SCAN = 2'd1, MODE_HOLD = 2'd2) and a clog2 function.
- One sub-module, onehot_dec: parametrised SW-to-N one-hot decoder, combinational, with an all-zero output for index >= N. It is instantiated once for the selection path.
- Everything else, including the counter, capture and flags, lives in chan_scan_mux.

## Test plan
- Reset: hold rst_n = 0 for 2 edges with in_bits = all ones → y = 0, out_sel = 0, cap_word = 0, cap_valid = 0, sel_err = 0. Release → y = 1 two edges later (DIRECT, sel = 0).
- DIRECT, N = 32: in_bits = 32'h8000_0001, sel sequence 0, 31, 5 on consecutive edges → y = 1, 1, 0 with out_sel = 0, 31, 5, each 2 edges after its sel.
- Out of range, N = 20: DIRECT sel = 19, then sel = 25 → sel_err pulses once, out_sel stays 19, and y keeps following in_bits[19].
- Full sweep, N = 32: in_bits = 32'hDEAD_BEEF static, enter SCAN → cap_valid pulses at E+34 with cap_word = 32'hDEAD_BEEF, then again every 32 cycles.
- Non-power-of-two wrap, N = 5: SCAN for 12 cycles → out_sel runs 0,1,2,3,4,0,1,… and never reaches 5–7; cap_valid pulses every 5 cycles.
- Abort: SCAN, switch to HOLD after 10 edges, then back to SCAN → no cap_valid during the aborted sweep, cap_word unchanged, and the new sweep restarts at index 0 with a full N-cycle latency.
